// File: rtl/spi_reg_master.sv
// SPI register-access initiator: shifts one 16-bit {rw, addr, wdata} frame out
// on MOSI and collects the last 8 MISO bits into rdata. All four SPI modes are supported.
module spi_reg_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int REG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic                  busy,
  output logic                  done,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] EDGES    = 6'd32;

  state_t               state, state_n;
  logic [7:0]           hcnt, hcnt_n;
  logic [5:0]           ecnt, ecnt_n;
  logic [15:0]          sh, sh_n;
  logic [REG_WIDTH-1:0] rx, rx_n, rdata_n;
  logic                 cpol, cpol_n, cpha, cpha_n;
  logic                 busy_n, done_n, cs_n_n, sclk_n, mosi_n;
  logic                 tick;
  logic [5:0]           edge_nxt;
  logic [15:0]          frame;

  assign frame    = {rw, 7'(addr), 8'(wdata)};
  assign tick     = (hcnt == DIV_LAST);
  assign edge_nxt = ecnt + 6'd1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      hcnt     <= '0;
      ecnt     <= '0;
      sh       <= '0;
      rx       <= '0;
      rdata    <= '0;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      ecnt     <= ecnt_n;
      sh       <= sh_n;
      rx       <= rx_n;
      rdata    <= rdata_n;
      cpol     <= cpol_n;
      cpha     <= cpha_n;
      busy     <= busy_n;
      done     <= done_n;
      spi_cs_n <= cs_n_n;
      spi_clk  <= sclk_n;
      spi_mosi <= mosi_n;
    end
  end

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    ecnt_n  = ecnt;
    sh_n    = sh;
    rx_n    = rx;
    rdata_n = rdata;
    cpol_n  = cpol;
    cpha_n  = cpha;
    busy_n  = busy;
    done_n  = done;
    cs_n_n  = spi_cs_n;
    sclk_n  = spi_clk;
    mosi_n  = spi_mosi;
    if (ena) begin
      done_n = 1'b0;
      hcnt_n = tick ? 8'd0 : hcnt + 8'd1;
      // Late capture: MISO is taken in the last cycle before the following toggle,
      // giving a synchronizing target most of a half-period to respond.
      if ((state == ACTIVE || state == HOLD) && tick && ecnt != 6'd0 && (ecnt[0] != cpha))
        rx_n = {rx[REG_WIDTH-2:0], spi_miso};
      case (state)
        IDLE: begin
          sclk_n = mode[1];
          busy_n = 1'b0;
          hcnt_n = 8'd0;
          // The done cycle is already IDLE; blocking it keeps the next accept one cycle later.
          if (start && !done) begin
            state_n = ACTIVE;
            busy_n  = 1'b1;
            cs_n_n  = 1'b0;
            cpol_n  = mode[1];
            cpha_n  = mode[0];
            ecnt_n  = 6'd0;
            if (mode[0]) begin
              sh_n   = frame;
              mosi_n = 1'b0;
            end else begin
              sh_n   = {frame[14:0], 1'b0};
              mosi_n = frame[15];
            end
          end
        end
        ACTIVE: if (tick) begin
          sclk_n = ~spi_clk;
          ecnt_n = edge_nxt;
          if (edge_nxt[0] == cpha && edge_nxt != EDGES) begin
            mosi_n = sh[15];
            sh_n   = {sh[14:0], 1'b0};
          end
          if (edge_nxt == EDGES) state_n = HOLD;
        end
        HOLD: if (tick) begin
          cs_n_n  = 1'b1;
          mosi_n  = 1'b0;
          state_n = GAP;
        end
        GAP: if (tick) begin
          done_n  = 1'b1;
          rdata_n = rx;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // cpol is kept with the rest of the latched frame context for visibility.
  logic unused_cpol;
  assign unused_cpol = cpol;
endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: a behavioural SPI target decodes MOSI frames and
// returns per-address status bytes on MISO with a 3-cycle delay.
module tb_spi_reg_master;
  localparam int D  = 4;
  localparam int AW = 4;

  logic clk = 1'b0, rstb = 1'b0, ena = 1'b1, start = 1'b0, rw = 1'b0, spi_miso = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [AW-1:0] addr = '0;
  logic [7:0] wdata = 8'd0;
  logic busy, done, spi_cs_n, spi_clk, spi_mosi;
  logic [7:0] rdata;

  int checks = 0, errors = 0, cyc = 0;

  spi_reg_master #(.CLK_DIV(D), .ADDR_WIDTH(AW), .REG_WIDTH(8)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .start(start), .rw(rw),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // target / monitor state
  logic [7:0]  status [0:127];
  logic [1:0]  m_mode = 2'd0;
  int t_edges = 0, t_rxn = 0, cs_low_cnt = 0, mosi_viol = 0, mosi_nonfall = 0, first_chg = -1;
  int cs_falls = 0, cs_high_run = 0, min_gap = 1 << 30, last_cs_low = 0, last_edges = 0;
  logic [15:0] t_rx = '0, last_rx = '0;
  logic [6:0]  t_addr = '0;
  logic        t_bit = 1'b0;

  initial begin
    logic p_clk, p_cs, p_mosi, samp;
    logic [2:0] dly;
    int j;
    p_clk = 1'b0; p_cs = 1'b1; p_mosi = 1'b0; dly = '0;
    forever begin
      @(negedge clk);
      if (p_cs && !spi_cs_n) begin
        if (cs_falls > 0 && cs_high_run < min_gap) min_gap = cs_high_run;
        cs_falls++; t_edges = 0; t_rx = '0; t_rxn = 0; t_addr = '0;
        cs_low_cnt = 0; mosi_viol = 0; mosi_nonfall = 0; first_chg = -1;
      end
      if (!p_cs && spi_cs_n) begin
        last_rx = t_rx; last_cs_low = cs_low_cnt; last_edges = t_edges; cs_high_run = 0;
      end
      if (!spi_cs_n) begin
        cs_low_cnt++;
        samp = 1'b0;
        if (!p_cs && spi_clk !== p_clk) begin
          t_edges++;
          samp = ((t_edges % 2) == 1) != m_mode[0];
          if (samp) begin
            t_rx = {t_rx[14:0], spi_mosi};
            t_rxn++;
            if (t_rxn == 8) t_addr = t_rx[6:0];
          end
        end
        if (!p_cs && spi_mosi !== p_mosi) begin
          if (first_chg < 0) first_chg = t_edges;
          if (spi_clk === p_clk || samp) mosi_viol++;
          if (!(p_clk === 1'b1 && spi_clk === 1'b0)) mosi_nonfall++;
        end
        // bit index the target should be presenting now
        j = m_mode[0] ? ((t_edges == 0) ? 0 : (t_edges - 1) / 2) : t_edges / 2;
        if (j > 15) j = 15;
        t_bit = (j < 8) ? 1'b0 : status[t_addr][15 - j];
      end else begin
        cs_high_run++;
        t_bit = 1'b0;
      end
      dly = {dly[1:0], t_bit};
      spi_miso = dly[2];
      p_clk = spi_clk; p_cs = spi_cs_n; p_mosi = spi_mosi;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_frame(input logic r, input logic [AW-1:0] a, input logic [7:0] wd);
    return {r, 7'(a), wd};
  endfunction

  task automatic run_frame(input logic [1:0] md, input logic r, input logic [AW-1:0] a,
                           input logic [7:0] wd, input int stall_at, input bit scramble,
                           output int lat, output logic t0_ok);
    int t0, n;
    bit stalled;
    m_mode = md; mode = md; rw = r; addr = a; wdata = wd; start = 1'b1;
    step();
    start = 1'b0;
    if (scramble) mode = 2'($urandom);
    t0 = cyc;
    t0_ok = (spi_cs_n === 1'b0) && (busy === 1'b1);
    n = 0; stalled = 0; lat = -1;
    while (done !== 1'b1 && n < 3000) begin
      if (stall_at > 0 && !stalled && t_edges >= stall_at) begin
        ena = 1'b0;
        repeat (10) step();
        ena = 1'b1;
        stalled = 1;
      end else begin
        step();
        n++;
      end
    end
    if (done === 1'b1) lat = cyc - t0;
    step();
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h expected 00", rdata); end
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b expected 1", spi_cs_n); end
    checks++; if (spi_clk !== 1'b0 || spi_mosi !== 1'b0) begin
      errors++; $display("FAIL rst_clk_mosi: got %b%b expected 00", spi_clk, spi_mosi); end
    rstb = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_write_mode0();
    int lat; logic ok;
    run_frame(2'd0, 1'b1, 4'd3, 8'hA5, 0, 0, lat, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_t0: got %b expected 1", ok); end
    checks++; if (last_rx !== 16'h83A5) begin errors++; $display("FAIL wr_frame: got %h expected 83a5", last_rx); end
    checks++; if (last_cs_low != 33 * D) begin errors++; $display("FAIL wr_cs_low: got %0d expected %0d", last_cs_low, 33 * D); end
    checks++; if (last_edges != 32) begin errors++; $display("FAIL wr_toggles: got %0d expected 32", last_edges); end
    checks++; if (lat != 34 * D) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, 34 * D); end
    checks++; if (rdata !== status[3]) begin errors++; $display("FAIL wr_rdata: got %h expected %h", rdata, status[3]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_read_modes();
    int lat; logic ok; logic [7:0] wd;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m); m_mode = 2'(m);
      repeat (3) step();
      checks++; if (spi_clk !== mode[1]) begin errors++; $display("FAIL rd_idle_pre m%0d: got %b expected %b", m, spi_clk, mode[1]); end
      wd = 8'($urandom);
      run_frame(2'(m), 1'b0, 4'd0, wd, 0, 0, lat, ok);
      checks++; if (rdata !== 8'hCA) begin errors++; $display("FAIL rd_data m%0d: got %h expected ca", m, rdata); end
      checks++; if (last_rx !== exp_frame(1'b0, 4'd0, wd)) begin
        errors++; $display("FAIL rd_frame m%0d: got %h expected %h", m, last_rx, exp_frame(1'b0, 4'd0, wd)); end
      checks++; if (lat != 34 * D) begin errors++; $display("FAIL rd_latency m%0d: got %0d expected %0d", m, lat, 34 * D); end
      checks++; if (spi_clk !== 1'(m >> 1)) begin errors++; $display("FAIL rd_idle_post m%0d: got %b expected %0d", m, spi_clk, m >> 1); end
    end
  endtask

  task automatic test_mode3_timing();
    int lat; logic ok;
    run_frame(2'd3, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 0, 0, lat, ok);
    checks++; if (mosi_nonfall != 0) begin errors++; $display("FAIL m3_nonfall: got %0d expected 0", mosi_nonfall); end
    checks++; if (mosi_viol != 0) begin errors++; $display("FAIL m3_unstable: got %0d expected 0", mosi_viol); end
    checks++; if (first_chg != 1) begin errors++; $display("FAIL m3_first_edge: got %0d expected 1", first_chg); end
  endtask

  task automatic test_random();
    int lat; logic ok; logic [1:0] md; logic r; logic [AW-1:0] a; logic [7:0] wd;
    for (int k = 0; k < 8; k++) begin
      md = 2'($urandom); r = 1'($urandom); a = 4'($urandom_range(0, 15)); wd = 8'($urandom);
      run_frame(md, r, a, wd, 0, 1, lat, ok);
      checks++; if (last_rx !== exp_frame(r, a, wd) || mosi_viol != 0) begin
        errors++; $display("FAIL rnd_frame %0d: got %h/%0d expected %h/0", k, last_rx, mosi_viol, exp_frame(r, a, wd)); end
      checks++; if (rdata !== status[7'(a)] || lat != 34 * D) begin
        errors++; $display("FAIL rnd_rdata %0d: got %h/%0d expected %h/%0d", k, rdata, lat, status[7'(a)], 34 * D); end
    end
  endtask

  task automatic test_back_to_back();
    int dones, n, f0;
    m_mode = 2'd1; mode = 2'd1; rw = 1'b0; addr = 4'd5; wdata = 8'h3C;
    min_gap = 1 << 30; f0 = cs_falls; dones = 0; n = 0;
    start = 1'b1;
    while (dones < 3 && n < 2000) begin
      step(); n++;
      if (done === 1'b1) begin
        dones++;
        if (dones == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (20) step();
    checks++; if (dones != 3) begin errors++; $display("FAIL b2b_dones: got %0d expected 3", dones); end
    checks++; if (cs_falls - f0 != 3) begin errors++; $display("FAIL b2b_frames: got %0d expected 3", cs_falls - f0); end
    checks++; if (min_gap < D) begin errors++; $display("FAIL b2b_gap: got %0d expected >= %0d", min_gap, D); end
    checks++; if (rdata !== status[5]) begin errors++; $display("FAIL b2b_rdata: got %h expected %h", rdata, status[5]); end
    // single frame with a stray start pulse while busy
    f0 = cs_falls; n = 0;
    start = 1'b1; step(); start = 1'b0;
    repeat (30) step();
    start = 1'b1; step(); start = 1'b0;
    while (done !== 1'b1 && n < 2000) begin step(); n++; end
    repeat (20) step();
    checks++; if (cs_falls - f0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_ignored: got %0d frames busy=%b expected 1 frames busy=0", cs_falls - f0, busy); end
  endtask

  task automatic test_stall();
    int lat; logic ok; logic [7:0] wd;
    wd = 8'($urandom);
    run_frame(2'd2, 1'b0, 4'd0, wd, 7, 0, lat, ok);
    checks++; if (lat != 34 * D + 10) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, 34 * D + 10); end
    checks++; if (last_cs_low != 33 * D + 10) begin errors++; $display("FAIL stall_cs_low: got %0d expected %0d", last_cs_low, 33 * D + 10); end
    checks++; if (rdata !== 8'hCA || last_rx !== exp_frame(1'b0, 4'd0, wd)) begin
      errors++; $display("FAIL stall_data: got %h/%h expected ca/%h", rdata, last_rx, exp_frame(1'b0, 4'd0, wd)); end
  endtask

  task automatic test_reset_midframe();
    int n, late_done, lat; logic ok;
    m_mode = 2'd0; mode = 2'd0; rw = 1'b0; addr = 4'd0; wdata = 8'h11;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (t_edges < 20 && n < 2000) begin step(); n++; end
    checks++; if (t_edges < 20) begin errors++; $display("FAIL rstmid_reach: got %0d edges expected 20", t_edges); end
    rstb = 1'b0;
    #1;
    checks++; if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got cs_n=%b busy=%b expected 1/0", spi_cs_n, busy); end
    checks++; if (rdata !== 8'h00 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_rdata: got %h done=%b expected 00/0", rdata, done); end
    step(); step();
    rstb = 1'b1;
    late_done = 0;
    repeat (200) begin step(); if (done === 1'b1) late_done++; end
    checks++; if (late_done != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", late_done); end
    run_frame(2'd0, 1'b0, 4'd0, 8'h5A, 0, 0, lat, ok);
    checks++; if (rdata !== 8'hCA || lat != 34 * D || last_rx !== 16'h005A) begin
      errors++; $display("FAIL rstmid_next: got %h/%0d/%h expected ca/%0d/005a", rdata, lat, last_rx, 34 * D); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) status[i] = 8'($urandom);
    status[0] = 8'hCA;
    test_reset();
    test_write_mode0();
    test_read_modes();
    test_mode3_timing();
    test_random();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
